target_generator: RTL and testbench

- Producer end of the REACHED_TARGET interface consumed by Score_counter.
- Places a pseudo-random target on the play grid and compares it with the player position every cycle.
- On a hit, emits a one-cycle REACHED_TARGET pulse and relocates the target.
- Sits between the player-position logic and Score_counter / VGA target drawing.

---
 rtl/target_pkg.sv | 31 +++
 rtl/target_lfsr.sv | 36 +++
 rtl/target_generator.sv | 165 ++++++++++++++++
 tb/tb_target_generator.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/target_pkg.sv
// Shared types and constants for the target generator: FSM states, LFSR tap mask,
// default playfield geometry and the LFSR step function.
package target_pkg;

    typedef enum logic [1:0] {
        REGEN = 2'd0,
        ARMED = 2'd1,
        HIT   = 2'd2
    } state_e;

    localparam int LFSR_W = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    localparam int          DEF_X_W   = 8;
    localparam int          DEF_Y_W   = 7;
    localparam int unsigned DEF_X_MAX = 159;
    localparam int unsigned DEF_Y_MAX = 119;

    // Right-shifting Galois step for taps 16,14,13,11.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        logic [LFSR_W-1:0] n;
        n = {1'b0, s[LFSR_W-1:1]};
        if (s[0]) begin
            n = n ^ LFSR_TAPS;
        end else begin
            n = n;
        end
        return n;
    endfunction

endpackage

// File: rtl/target_lfsr.sv
// Free-running 16-bit Galois LFSR with seed load on reset and recovery from the
// all-zero lock-up state.
module target_lfsr
    import target_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_d;

    // Next LFSR value; an all-zero register would never move again, so reseed it.
    always_comb begin
        if (state_q == {LFSR_W{1'b0}}) begin
            state_d = SEED;
        end else begin
            state_d = lfsr_step(state_q);
        end
    end

    // LFSR state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/target_generator.sv
// Places a pseudo-random target on the grid and pulses REACHED_TARGET when the player
// lands on it. Define TARGET_TIMEOUT_EN to relocate a target left untouched too long.
module target_generator
    import target_pkg::*;
#(
    parameter int                X_W            = DEF_X_W,
    parameter int                Y_W            = DEF_Y_W,
    parameter int unsigned       X_MAX          = DEF_X_MAX,
    parameter int unsigned       Y_MAX          = DEF_Y_MAX,
    parameter logic [LFSR_W-1:0] LFSR_SEED      = 16'hACE1,
    parameter int unsigned       TIMEOUT_CYCLES = 50_000_000
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic           ENABLE,
    input  logic [X_W-1:0] PLAYER_X,
    input  logic [Y_W-1:0] PLAYER_Y,
    output logic [X_W-1:0] TARGET_X,
    output logic [Y_W-1:0] TARGET_Y,
    output logic           TARGET_VALID,
    output logic           REACHED_TARGET,
    output logic           TARGET_MISSED
);

    localparam logic [X_W-1:0] X_LIM = X_W'(X_MAX);
    localparam logic [Y_W-1:0] Y_LIM = Y_W'(Y_MAX);

    logic [LFSR_W-1:0] lfsr_s;
    logic [X_W-1:0]    cand_x_s;
    logic [Y_W-1:0]    cand_y_s;
    logic              cand_ok_s;
    logic              hit_s;
    logic              timeout_s;
    logic              unused_lfsr_s;

    state_e         state_q,   state_d;
    logic [X_W-1:0] target_x_q, target_x_d;
    logic [Y_W-1:0] target_y_q, target_y_d;
    logic           valid_q,   valid_d;
    logic           reached_q, reached_d;
    logic           missed_q,  missed_d;

    target_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (CLK),
        .rst_n (RESET),
        .state (lfsr_s)
    );

    assign cand_x_s      = lfsr_s[X_W-1:0];
    assign cand_y_s      = lfsr_s[LFSR_W-1:LFSR_W-Y_W];
    assign unused_lfsr_s = ^lfsr_s;

    // A candidate under the player would be hit instantly, so it is rejected too.
    assign cand_ok_s = (cand_x_s <= X_LIM) && (cand_y_s <= Y_LIM) &&
                       !((cand_x_s == PLAYER_X) && (cand_y_s == PLAYER_Y));

    assign hit_s = ENABLE && (PLAYER_X == target_x_q) && (PLAYER_Y == target_y_q);

`ifdef TARGET_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 32'd2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign timeout_s = ENABLE && (cnt_q == CNT_LAST);

    // Counts enabled ARMED cycles; any exit from ARMED clears it.
    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == ARMED) && !hit_s && !timeout_s) begin
            if (ENABLE) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            cnt_d = {CNT_W{1'b0}};
        end
    end

    // Timeout counter register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic [31:0] unused_timeout_s;

    assign timeout_s        = 1'b0;
    assign unused_timeout_s = 32'(TIMEOUT_CYCLES);
`endif

    // FSM next state and next output values; pulses default low so they last one cycle.
    always_comb begin
        state_d    = state_q;
        target_x_d = target_x_q;
        target_y_d = target_y_q;
        valid_d    = valid_q;
        reached_d  = 1'b0;
        missed_d   = 1'b0;
        case (state_q)
            REGEN: begin
                if (cand_ok_s) begin
                    target_x_d = cand_x_s;
                    target_y_d = cand_y_s;
                    valid_d    = 1'b1;
                    state_d    = ARMED;
                end else begin
                    state_d    = REGEN;
                end
            end
            ARMED: begin
                if (hit_s) begin
                    reached_d = 1'b1;
                    state_d   = HIT;
                end else if (timeout_s) begin
                    missed_d  = 1'b1;
                    valid_d   = 1'b0;
                    state_d   = REGEN;
                end else begin
                    state_d   = ARMED;
                end
            end
            HIT: begin
                valid_d = 1'b0;
                state_d = REGEN;
            end
            default: begin
                valid_d = 1'b0;
                state_d = REGEN;
            end
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= REGEN;
            target_x_q <= {X_W{1'b0}};
            target_y_q <= {Y_W{1'b0}};
            valid_q    <= 1'b0;
            reached_q  <= 1'b0;
            missed_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_x_q <= target_x_d;
            target_y_q <= target_y_d;
            valid_q    <= valid_d;
            reached_q  <= reached_d;
            missed_q   <= missed_d;
        end
    end

    assign TARGET_X       = target_x_q;
    assign TARGET_Y       = target_y_q;
    assign TARGET_VALID   = valid_q;
    assign REACHED_TARGET = reached_q;
    assign TARGET_MISSED  = missed_q;

endmodule

// File: tb/tb_target_generator.sv
// Directed self-checking bench for target_generator; the timeout scenario runs only
// when TARGET_TIMEOUT_EN is defined (DUT built with TIMEOUT_CYCLES=10).
module tb_target_generator;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       ENABLE = 1'b0;
    logic [7:0] PLAYER_X = 8'd200;
    logic [6:0] PLAYER_Y = 7'd127;
    logic [7:0] TARGET_X;
    logic [6:0] TARGET_Y;
    logic       TARGET_VALID;
    logic       REACHED_TARGET;
    logic       TARGET_MISSED;

    int checks = 0;
    int errors = 0;

    target_generator #(
        .TIMEOUT_CYCLES (10)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .ENABLE         (ENABLE),
        .PLAYER_X       (PLAYER_X),
        .PLAYER_Y       (PLAYER_Y),
        .TARGET_X       (TARGET_X),
        .TARGET_Y       (TARGET_Y),
        .TARGET_VALID   (TARGET_VALID),
        .REACHED_TARGET (REACHED_TARGET),
        .TARGET_MISSED  (TARGET_MISSED)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Ticks until TARGET_VALID is high, at most 64 edges; n is the number of edges taken.
    task automatic wait_valid(output int n);
        n = 0;
        while (TARGET_VALID !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        RESET = 1'b0;
        ENABLE = 1'b0;
        PLAYER_X = 8'd200;
        PLAYER_Y = 7'd127;
        repeat (3) tick();
        checks++;
        if ({TARGET_X, TARGET_Y, TARGET_VALID, REACHED_TARGET, TARGET_MISSED} !== 18'd0) begin
            errors++;
            $display("FAIL reset_outputs: got x=%0d y=%0d v=%b r=%b m=%b, expected all 0",
                     TARGET_X, TARGET_Y, TARGET_VALID, REACHED_TARGET, TARGET_MISSED);
        end
        RESET = 1'b1;
        wait_valid(n);
        // Seed ACE1 gives x=225 (rejected); next state E270 gives (112,113).
        checks++;
        if (n !== 2) begin
            errors++;
            $display("FAIL reset_valid_latency: valid after %0d edges, expected 2", n);
        end
        checks++;
        if (TARGET_X !== 8'd112 || TARGET_Y !== 7'd113) begin
            errors++;
            $display("FAIL reset_first_target: got (%0d,%0d), expected (112,113)", TARGET_X, TARGET_Y);
        end
        checks++;
        if (TARGET_X > 8'd159 || TARGET_Y > 7'd119) begin
            errors++;
            $display("FAIL reset_target_range: got (%0d,%0d), expected x<=159 y<=119", TARGET_X, TARGET_Y);
        end
    endtask

    task automatic test_basic_hit();
        int n;
        int pulses = 0;
        ENABLE = 1'b1;
        checks++;
        if (REACHED_TARGET !== 1'b0) begin
            errors++;
            $display("FAIL hit_pre: REACHED_TARGET=%b, expected 0", REACHED_TARGET);
        end
        PLAYER_X = TARGET_X;
        PLAYER_Y = TARGET_Y;
        tick();
        checks++;
        if (REACHED_TARGET !== 1'b1 || TARGET_VALID !== 1'b1) begin
            errors++;
            $display("FAIL hit_pulse: r=%b v=%b, expected r=1 v=1", REACHED_TARGET, TARGET_VALID);
        end
        tick();
        checks++;
        if (REACHED_TARGET !== 1'b0 || TARGET_VALID !== 1'b0) begin
            errors++;
            $display("FAIL hit_after: r=%b v=%b, expected r=0 v=0", REACHED_TARGET, TARGET_VALID);
        end
        n = 0;
        while (TARGET_VALID !== 1'b1 && n < 64) begin
            tick();
            n++;
            if (REACHED_TARGET === 1'b1) pulses++;
        end
        checks++;
        if (TARGET_VALID !== 1'b1 || pulses !== 0 || n < 1) begin
            errors++;
            $display("FAIL hit_regen: v=%b pulses=%0d edges=%0d, expected v=1 pulses=0 edges>=1",
                     TARGET_VALID, pulses, n);
        end
        checks++;
        if (TARGET_X === PLAYER_X && TARGET_Y === PLAYER_Y) begin
            errors++;
            $display("FAIL hit_new_target: target (%0d,%0d) equals player, expected different",
                     TARGET_X, TARGET_Y);
        end
    endtask

    task automatic test_parked();
        int bad = 0;
        for (int i = 0; i < 200; i++) begin
            int  pulses = 0;
            int  n = 0;
            bit  seen_low = 1'b0;
            bit  prev = 1'b0;
            bit  dbl = 1'b0;
            checks++;
            if (TARGET_X === PLAYER_X && TARGET_Y === PLAYER_Y) begin
                errors++;
                $display("FAIL parked_target_eq_player: iter %0d target (%0d,%0d), expected != player",
                         i, TARGET_X, TARGET_Y);
            end
            PLAYER_X = TARGET_X;
            PLAYER_Y = TARGET_Y;
            while (!(seen_low && TARGET_VALID === 1'b1) && n < 80) begin
                tick();
                n++;
                if (REACHED_TARGET === 1'b1) pulses++;
                if (prev && REACHED_TARGET === 1'b1) dbl = 1'b1;
                prev = (REACHED_TARGET === 1'b1);
                if (TARGET_VALID !== 1'b1) seen_low = 1'b1;
            end
            if (pulses !== 1 || dbl || TARGET_VALID !== 1'b1) begin
                bad++;
                if (bad < 5)
                    $display("FAIL parked_pulse: iter %0d pulses=%0d double=%b v=%b, expected 1 0 1",
                             i, pulses, dbl, TARGET_VALID);
            end
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL parked_summary: %0d bad relocations, expected 0", bad);
        end
    endtask

    task automatic test_disabled();
        int pulses = 0;
        int invalid = 0;
        int missed = 0;
        ENABLE = 1'b0;
        PLAYER_X = TARGET_X;
        PLAYER_Y = TARGET_Y;
        repeat (1000) begin
            tick();
            if (REACHED_TARGET === 1'b1) pulses++;
            if (TARGET_VALID !== 1'b1) invalid++;
            if (TARGET_MISSED === 1'b1) missed++;
        end
        checks++;
        if (pulses !== 0 || invalid !== 0 || missed !== 0) begin
            errors++;
            $display("FAIL disabled_hold: pulses=%0d invalid=%0d missed=%0d, expected 0 0 0",
                     pulses, invalid, missed);
        end
        ENABLE = 1'b1;
        tick();
        checks++;
        if (REACHED_TARGET !== 1'b1) begin
            errors++;
            $display("FAIL disabled_resume_pulse: REACHED_TARGET=%b, expected 1", REACHED_TARGET);
        end
        tick();
        checks++;
        if (REACHED_TARGET !== 1'b0) begin
            errors++;
            $display("FAIL disabled_pulse_width: REACHED_TARGET=%b, expected 0", REACHED_TARGET);
        end
    endtask

    task automatic test_reset_during_hit();
        int n;
        int pulses = 0;
        wait_valid(n);
        PLAYER_X = TARGET_X;
        PLAYER_Y = TARGET_Y;
        tick();
        checks++;
        if (REACHED_TARGET !== 1'b1) begin
            errors++;
            $display("FAIL rst_hit_pulse: REACHED_TARGET=%b, expected 1", REACHED_TARGET);
        end
        #2;
        RESET = 1'b0;
        #1;
        checks++;
        if (REACHED_TARGET !== 1'b0 || TARGET_VALID !== 1'b0 || TARGET_X !== 8'd0) begin
            errors++;
            $display("FAIL rst_async_clear: r=%b v=%b x=%0d, expected 0 0 0",
                     REACHED_TARGET, TARGET_VALID, TARGET_X);
        end
        tick();
        tick();
        RESET = 1'b1;
        repeat (100) begin
            tick();
            if (REACHED_TARGET === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL rst_no_second_pulse: pulses=%0d, expected 0", pulses);
        end
        checks++;
        if (TARGET_X === PLAYER_X && TARGET_Y === PLAYER_Y) begin
            errors++;
            $display("FAIL rst_target_eq_player: target (%0d,%0d), expected != player", TARGET_X, TARGET_Y);
        end
    endtask

`ifdef TARGET_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        int early = 0;
        RESET = 1'b0;
        PLAYER_X = 8'd200;
        PLAYER_Y = 7'd127;
        ENABLE = 1'b1;
        tick();
        RESET = 1'b1;
        wait_valid(n);
        repeat (9) begin
            tick();
            if (TARGET_MISSED === 1'b1) early++;
        end
        checks++;
        if (early !== 0) begin
            errors++;
            $display("FAIL timeout_early: %0d early TARGET_MISSED, expected 0", early);
        end
        tick();
        checks++;
        if (TARGET_MISSED !== 1'b1 || TARGET_VALID !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: m=%b v=%b, expected m=1 v=0", TARGET_MISSED, TARGET_VALID);
        end
        tick();
        checks++;
        if (TARGET_MISSED !== 1'b0) begin
            errors++;
            $display("FAIL timeout_width: TARGET_MISSED=%b, expected 0", TARGET_MISSED);
        end
        wait_valid(n);
        repeat (9) tick();
        PLAYER_X = TARGET_X;
        PLAYER_Y = TARGET_Y;
        tick();
        checks++;
        if (REACHED_TARGET !== 1'b1 || TARGET_MISSED !== 1'b0) begin
            errors++;
            $display("FAIL timeout_hit_wins: r=%b m=%b, expected r=1 m=0", REACHED_TARGET, TARGET_MISSED);
        end
        tick();
        checks++;
        if (TARGET_MISSED !== 1'b0 || REACHED_TARGET !== 1'b0) begin
            errors++;
            $display("FAIL timeout_hit_after: r=%b m=%b, expected 0 0", REACHED_TARGET, TARGET_MISSED);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_hit();
        test_parked();
        test_disabled();
        test_reset_during_hit();
`ifdef TARGET_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
